// File: rtl/opl_pkg.sv
// opl_pkg: register indices, status bit positions and port offsets shared by the OPL timer block
package opl_pkg;
  localparam logic [7:0] REG_T1 = 8'h02;
  localparam logic [7:0] REG_T2 = 8'h03;
  localparam logic [7:0] REG_CTRL = 8'h04;
  localparam logic [7:0] REG_NEW = 8'h05;
  localparam int ST_IRQ = 7;
  localparam int ST_F1 = 6;
  localparam int ST_F2 = 5;
  localparam logic [1:0] OFF_IDX0 = 2'd0;
  localparam logic [1:0] OFF_DAT0 = 2'd1;
  localparam logic [1:0] OFF_IDX1 = 2'd2;
  localparam logic [1:0] OFF_DAT1 = 2'd3;
endpackage

// File: rtl/opl_timer_block_timer.sv
// opl_timer: one reloading 8-bit OPL timer with preset, start-edge load, mask and overflow flag
module opl_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       preset_we,
  input  logic       ctrl_we,
  input  logic       clr,
  input  logic       mask_d,
  input  logic       start_d,
  input  logic [7:0] din,
  output logic       flag
);
  logic [7:0] preset, cnt;
  logic       mask, start, ovf;
  assign ovf = start && tick && cnt == 8'hFF;
  always_ff @(posedge clk) begin
    if (reset) begin
      preset <= '0;
      cnt <= '0;
      mask <= 1'b0;
      start <= 1'b0;
      flag <= 1'b0;
    end else begin
      if (preset_we) preset <= din;
      if (ctrl_we) begin
        mask <= mask_d;
        start <= start_d;
      end
      if (ctrl_we && start_d && !start) cnt <= preset;
      else if (start && tick) cnt <= ovf ? preset : cnt + 8'd1;
      // a clear landing on an overflow cycle wins
      if (clr) flag <= 1'b0;
      else if (ovf && !mask) flag <= 1'b1;
    end
  end
endmodule

// File: rtl/opl_timer_block.sv
// opl_timer_block: AdLib/OPL I/O block with OPL2 timers, toggle handshake and optional OPL3 bank 1
// irq is driven from the status byte only when OPL_IRQ_EN is defined, otherwise tied low.
module opl_timer_block
  import opl_pkg::*;
#(
  parameter logic [11:0] BASE_PORT = 12'h388,
  parameter int          OPL3      = 0,
  parameter int          T1_DIV    = 4000,
  parameter int          T2_RATIO  = 4,
  parameter int          RD_DELAY  = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] port,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic        cpu_iordin,
  output logic        cpu_iordout,
  input  logic        cpu_iowrin,
  output logic        cpu_iowrout,
  output logic        irq,
  output logic        opl3_new,
  output logic [7:0]  activity
);
  localparam int W1 = $clog2(T1_DIV + 1);
  localparam int W2 = $clog2(T2_RATIO + 1);
  localparam int RW = $clog2(RD_DELAY + 1);
  localparam logic [W1-1:0] P1_MAX = W1'(T1_DIV - 1);
  localparam logic [W2-1:0] P2_MAX = W2'(T2_RATIO - 1);
  localparam logic [RW-1:0] RD_INIT = RW'(RD_DELAY > 1 ? RD_DELAY - 2 : 0);
  localparam logic [11:0] NPORTS = OPL3 != 0 ? 12'd4 : 12'd2;
  logic [11:0]   off;
  logic [7:0]    idx0, idx1, status;
  logic [W1-1:0] pre;
  logic [W2-1:0] pre2;
  logic [RW-1:0] rd_cnt;
  logic          dec, wr, rd, rd_busy, tick1, tick2, flag1, flag2;
  logic          wr_idx0, wr_dat0, wr_idx1, wr_dat1, ctrl, clr;
  assign off = port - BASE_PORT;
  assign dec = off < NPORTS;
  assign wr = cpu_iowrin != cpu_iowrout;
  assign rd = cpu_iordin != cpu_iordout;
  assign wr_idx0 = wr && dec && off[1:0] == OFF_IDX0;
  assign wr_dat0 = wr && dec && off[1:0] == OFF_DAT0;
  assign wr_idx1 = wr && dec && off[1:0] == OFF_IDX1;
  assign wr_dat1 = wr && dec && off[1:0] == OFF_DAT1;
  assign ctrl = wr_dat0 && idx0 == REG_CTRL;
  assign clr = ctrl && din[7];
  assign tick1 = pre == P1_MAX;
  assign tick2 = tick1 && pre2 == P2_MAX;
  always_comb begin
    status = '0;
    status[ST_IRQ] = flag1 | flag2;
    status[ST_F1] = flag1;
    status[ST_F2] = flag2;
  end
  assign dout = dec ? status : 8'hFF;
`ifdef OPL_IRQ_EN
  assign irq = status[ST_IRQ];
`else
  assign irq = 1'b0;
`endif
  opl_timer u_t1 (
    .clk(clk), .reset(reset), .tick(tick1),
    .preset_we(wr_dat0 && idx0 == REG_T1), .ctrl_we(ctrl && !din[7]), .clr(clr),
    .mask_d(din[6]), .start_d(din[0]), .din(din), .flag(flag1)
  );
  opl_timer u_t2 (
    .clk(clk), .reset(reset), .tick(tick2),
    .preset_we(wr_dat0 && idx0 == REG_T2), .ctrl_we(ctrl && !din[7]), .clr(clr),
    .mask_d(din[5]), .start_d(din[1]), .din(din), .flag(flag2)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_iowrout <= 1'b0;
      cpu_iordout <= 1'b0;
      idx0 <= '0;
      idx1 <= '0;
      opl3_new <= 1'b0;
      activity <= '0;
      pre <= '0;
      pre2 <= '0;
      rd_busy <= 1'b0;
      rd_cnt <= '0;
    end else begin
      cpu_iowrout <= cpu_iowrin;
      if (wr_idx0) idx0 <= din;
      if (wr_idx1) idx1 <= din;
      if (wr_dat1 && idx1 == REG_NEW) opl3_new <= din[0];
      if (wr_dat0 || wr_dat1) activity <= activity + 8'd32;
      pre <= tick1 ? '0 : pre + 1'b1;
      if (tick1) pre2 <= tick2 ? '0 : pre2 + 1'b1;
      // the detection edge counts as the first of the RD_DELAY cycles
      if (rd_busy) begin
        if (rd_cnt == '0) begin
          rd_busy <= 1'b0;
          cpu_iordout <= cpu_iordin;
        end else rd_cnt <= rd_cnt - 1'b1;
      end else if (rd) begin
        if (dec && RD_DELAY > 1) begin
          rd_busy <= 1'b1;
          rd_cnt <= RD_INIT;
        end else cpu_iordout <= cpu_iordin;
      end
    end
  end
endmodule

// File: tb/tb_opl_timer_block.sv
// tb_opl_timer_block: directed checks of the OPL timer block, one OPL2-only and one OPL3 instance on a shared bus
module tb_opl_timer_block;
  localparam logic [11:0] BASE = 12'h388;
`ifdef OPL_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [11:0] port = BASE;
  logic [7:0] din = '0;
  logic iordin = 1'b0, iowrin = 1'b0;
  logic [7:0] dout0, dout3, act0, act3;
  logic rdo0, rdo3, wro0, wro3, irq0, irq3, new0, new3;
  int tests = 0, fails = 0, cyc = 0;

  opl_timer_block #(.OPL3(0), .T1_DIV(16)) dut (
    .clk(clk), .reset(reset), .port(port), .din(din), .dout(dout0),
    .cpu_iordin(iordin), .cpu_iordout(rdo0), .cpu_iowrin(iowrin), .cpu_iowrout(wro0),
    .irq(irq0), .opl3_new(new0), .activity(act0)
  );
  opl_timer_block #(.OPL3(1), .T1_DIV(16)) dut3 (
    .clk(clk), .reset(reset), .port(port), .din(din), .dout(dout3),
    .cpu_iordin(iordin), .cpu_iordout(rdo3), .cpu_iowrin(iowrin), .cpu_iowrout(wro3),
    .irq(irq3), .opl3_new(new3), .activity(act3)
  );

  always #5 clk = ~clk;
  // mirrors the free-running prescaler phase so writes can be aimed at tick edges
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    iordin = 1'b0;
    iowrin = 1'b0;
    port = BASE;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wr_at(input logic [11:0] p, input logic [7:0] d, input int m, input int ph);
    do @(negedge clk); while (cyc % m != ph);
    port = p;
    din = d;
    iowrin = ~iowrin;
    @(negedge clk);
    tests++;
    if (wro0 !== iowrin || wro3 !== iowrin) begin
      fails++;
      $display("FAIL write_ack: got %b/%b expected %b", wro0, wro3, iowrin);
    end
  endtask

  task automatic wr(input logic [11:0] p, input logic [7:0] d);
    wr_at(p, d, 1, 0);
  endtask

  task automatic rd(input logic [11:0] p, input bit sel, output logic [7:0] d, output int n);
    int k;
    @(negedge clk);
    port = p;
    iordin = ~iordin;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (((sel ? rdo3 : rdo0) !== iordin) && n < 200);
    d = sel ? dout3 : dout0;
    k = 0;
    while ((rdo0 !== iordin || rdo3 !== iordin) && k < 200) begin @(posedge clk); #1; k++; end
  endtask

  task automatic test_reset();
    do_reset();
    tests += 6;
    if (rdo0 !== 1'b0) begin fails++; $display("FAIL rst_iordout: got %b expected 0", rdo0); end
    if (wro0 !== 1'b0) begin fails++; $display("FAIL rst_iowrout: got %b expected 0", wro0); end
    if (act0 !== 8'h00) begin fails++; $display("FAIL rst_activity: got %h expected 00", act0); end
    if (new3 !== 1'b0) begin fails++; $display("FAIL rst_opl3_new: got %b expected 0", new3); end
    if (irq0 !== 1'b0) begin fails++; $display("FAIL rst_irq: got %b expected 0", irq0); end
    if (dout0 !== 8'h00) begin fails++; $display("FAIL rst_status: got %h expected 00", dout0); end
  endtask

  task automatic test_reset_mid_read();
    int n;
    do_reset();
    @(negedge clk);
    port = BASE;
    iordin = 1'b1;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (rdo0 !== 1'b0) begin fails++; $display("FAIL midrd_reset: got %b expected 0", rdo0); end
    reset = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (rdo0 !== 1'b1 && n < 200);
    tests++;
    if (n != 63) begin fails++; $display("FAIL midrd_redelay: got %0d cycles expected 63", n); end
  endtask

  task automatic test_detect();
    logic [7:0] d;
    int n;
    do_reset();
    wr(BASE, 8'h04);
    wr(BASE + 12'd1, 8'h60);
    wr(BASE + 12'd1, 8'h80);
    rd(BASE, 0, d, n);
    tests += 2;
    if (d !== 8'h00) begin fails++; $display("FAIL detect_status: got %h expected 00", d); end
    if (n != 63) begin fails++; $display("FAIL detect_delay: got %0d cycles expected 63", n); end
  endtask

  task automatic test_timer1();
    logic [7:0] d;
    int n;
    wr(BASE, 8'h02);
    wr(BASE + 12'd1, 8'hFF);
    wr(BASE, 8'h04);
    wr(BASE + 12'd1, 8'h21);
    repeat (40) @(negedge clk);
    rd(BASE, 0, d, n);
    tests += 2;
    if (d !== 8'hC0) begin fails++; $display("FAIL t1_status: got %h expected c0", d); end
    if (irq0 !== IRQ_ON) begin fails++; $display("FAIL t1_irq: got %b expected %b", irq0, IRQ_ON); end
    wr(BASE + 12'd1, 8'h80);
    tests += 2;
    if (dout0 !== 8'h00) begin fails++; $display("FAIL t1_clear: got %h expected 00", dout0); end
    if (irq0 !== 1'b0) begin fails++; $display("FAIL t1_clear_irq: got %b expected 0", irq0); end
    wr(BASE + 12'd1, 8'h00);
  endtask

  task automatic test_timer2();
    int n;
    do_reset();
    wr(BASE, 8'h03);
    wr(BASE + 12'd1, 8'hFE);
    wr(BASE, 8'h04);
    wr_at(BASE + 12'd1, 8'h02, 64, 0);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (dout0[5] !== 1'b1 && n < 300);
    tests += 3;
    if (n < 112 || n > 144) begin fails++; $display("FAIL t2_delay: got %0d cycles expected 112..144", n); end
    if (dout0 !== 8'hA0) begin fails++; $display("FAIL t2_status: got %h expected a0", dout0); end
    if (irq0 !== IRQ_ON) begin fails++; $display("FAIL t2_irq: got %b expected %b", irq0, IRQ_ON); end
  endtask

  task automatic test_mask();
    do_reset();
    wr(BASE, 8'h02);
    wr(BASE + 12'd1, 8'hFF);
    wr(BASE, 8'h04);
    wr(BASE + 12'd1, 8'h41);
    repeat (200) @(negedge clk);
    tests++;
    if (dout0 !== 8'h00) begin fails++; $display("FAIL mask_noflag: got %h expected 00", dout0); end
    wr(BASE + 12'd1, 8'h01);
    repeat (20) @(negedge clk);
    tests++;
    if (dout0 !== 8'hC0) begin fails++; $display("FAIL mask_reload: got %h expected c0", dout0); end
  endtask

  task automatic test_clear_race();
    do_reset();
    wr(BASE, 8'h02);
    wr(BASE + 12'd1, 8'hFF);
    wr(BASE, 8'h04);
    wr(BASE + 12'd1, 8'h01);
    repeat (20) @(negedge clk);
    tests++;
    if (dout0 !== 8'hC0) begin fails++; $display("FAIL race_pre: got %h expected c0", dout0); end
    wr_at(BASE + 12'd1, 8'h80, 16, 15);
    tests++;
    if (dout0 !== 8'h00) begin fails++; $display("FAIL race_clear: got %h expected 00", dout0); end
    repeat (16) @(negedge clk);
    tests++;
    if (dout0 !== 8'hC0) begin fails++; $display("FAIL race_next: got %h expected c0", dout0); end
  endtask

  task automatic test_opl3();
    logic [7:0] d;
    int n;
    do_reset();
    wr(BASE, 8'h02);
    wr(BASE + 12'd1, 8'hFF);
    wr(BASE + 12'd2, 8'h05);
    wr(BASE + 12'd3, 8'h01);
    tests += 4;
    if (new3 !== 1'b1) begin fails++; $display("FAIL opl3_new: got %b expected 1", new3); end
    if (new0 !== 1'b0) begin fails++; $display("FAIL opl2_new: got %b expected 0", new0); end
    if (act3 !== 8'h40) begin fails++; $display("FAIL opl3_act: got %h expected 40", act3); end
    if (act0 !== 8'h20) begin fails++; $display("FAIL opl2_act: got %h expected 20", act0); end
    wr(BASE + 12'd2, 8'h04);
    wr(BASE + 12'd3, 8'h01);
    repeat (40) @(negedge clk);
    port = BASE;
    #1;
    tests += 2;
    if (dout3 !== 8'h00) begin fails++; $display("FAIL opl3_notimer: got %h expected 00", dout3); end
    if (new3 !== 1'b1) begin fails++; $display("FAIL opl3_keep: got %b expected 1", new3); end
    rd(BASE + 12'd3, 1, d, n);
    tests += 2;
    if (d !== 8'h00) begin fails++; $display("FAIL opl3_rd: got %h expected 00", d); end
    if (n != 63) begin fails++; $display("FAIL opl3_rd_delay: got %0d cycles expected 63", n); end
    rd(12'h38A, 0, d, n);
    tests += 2;
    if (d !== 8'hFF) begin fails++; $display("FAIL undec_rd: got %h expected ff", d); end
    if (n != 1) begin fails++; $display("FAIL undec_delay: got %0d cycles expected 1", n); end
  endtask

  task automatic test_activity();
    do_reset();
    wr(BASE, 8'h00);
    wr(BASE + 12'd1, 8'h00);
    tests++;
    if (act0 !== 8'h20) begin fails++; $display("FAIL act_one: got %h expected 20", act0); end
    for (int i = 0; i < 7; i++) wr(BASE + 12'd1, 8'h00);
    tests++;
    if (act0 !== 8'h00) begin fails++; $display("FAIL act_wrap: got %h expected 00", act0); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_read();
    test_detect();
    test_timer1();
    test_timer2();
    test_mask();
    test_clear_race();
    test_opl3();
    test_activity();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
